// File: rtl/arb_pkg.sv
// Shared constants, state encoding and sizing helper for the one-hot grant arbiter.
package arb_pkg;

   localparam int unsigned N_DEFAULT = 16;

   // Pointer/index width for an N-wide request vector (at least one bit).
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot pick: first set request at or above ptr, wrapping N-1 -> 0.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic             any
);

   logic [N-1:0]   keep;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] lowest;

   // Lower copy only sees bits >= ptr; the upper copy supplies the wrapped search.
   always_comb begin
      keep   = {N{1'b1}} << ptr;
      dbl    = {req, req & keep};
      lowest = dbl & (~dbl + (2*N)'(1));
      onehot = lowest[N-1:0] | lowest[2*N-1:N];
      any    = |req;
   end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant and valid/ack hold.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotating pointer).
module rr_onehot_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         enable,
   input  logic         ack,
   output logic [N-1:0] grant,
   output logic         grant_valid
);

   localparam int unsigned IDX_W = idx_w(N);

   state_t           state;
   state_t           state_nx;
   logic [N-1:0]     grant_nx;
   logic             grant_valid_nx;
   logic [IDX_W-1:0] pick_ptr;
   logic [N-1:0]     pick_onehot;
   logic             pick_any;

`ifdef ARB_FIXED_PRIO_EN
`else
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_nx;
   logic [IDX_W-1:0] gidx;
   logic [IDX_W-1:0] gidx_inc;

   // Index of the currently held grant and its successor (N is a power of two).
   always_comb begin
      gidx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) gidx = gidx | IDX_W'(i);
      end
      gidx_inc = gidx + IDX_W'(1);
   end
`endif

   rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .any    (pick_any)
   );

   // Next state; one picker serves both the IDLE pick and the ack-time re-pick.
   always_comb begin
      state_nx       = state;
      grant_nx       = grant;
      grant_valid_nx = grant_valid;
`ifdef ARB_FIXED_PRIO_EN
      pick_ptr       = '0;
`else
      ptr_nx         = ptr;
      pick_ptr       = ptr;
`endif
      case (state)
         ST_IDLE: begin
            grant_nx       = '0;
            grant_valid_nx = 1'b0;
            if (enable && pick_any) begin
               grant_nx       = pick_onehot;
               grant_valid_nx = 1'b1;
               state_nx       = ST_GRANT;
            end
         end
         ST_GRANT: begin
`ifdef ARB_FIXED_PRIO_EN
`else
            pick_ptr = gidx_inc;
`endif
            if (ack) begin
`ifdef ARB_FIXED_PRIO_EN
`else
               ptr_nx = gidx_inc;
`endif
               if (enable && pick_any) begin
                  grant_nx = pick_onehot;
               end else begin
                  grant_nx       = '0;
                  grant_valid_nx = 1'b0;
                  state_nx       = ST_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
`else
         ptr         <= '0;
`endif
      end else begin
         state       <= state_nx;
         grant       <= grant_nx;
         grant_valid <= grant_valid_nx;
`ifdef ARB_FIXED_PRIO_EN
`else
         ptr         <= ptr_nx;
`endif
      end
   end

endmodule
